// File: rtl/hs_pkg.sv
// Definitions shared by both ends of the 4-phase valid/ready byte handshake.
package hs_pkg;

   localparam int HS_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      REL   = 2'd2,
      ABORT = 2'd3
   } hs_state_e;

endpackage

// File: rtl/hs_sync_fifo.sv
// Single-clock FIFO with registered full/level and a combinational head-word output.
module hs_sync_fifo
   import hs_pkg::*;
#(
   parameter int DATA_W = HS_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [LW-1:0]     level_nxt;
   logic              push_ok;
   logic              pop_ok;

   // A push while full is dropped, even when a pop happens in the same cycle.
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign empty   = (level == '0);
   assign rdata   = mem[rd_ptr];

   // NOTE: every signal written in always_comb gets a value before any branch, so no latch is inferred.
   always_comb begin
      level_nxt = level;
      case ({push_ok, pop_ok})
         2'b10:   level_nxt = level + 1'b1;
         2'b01:   level_nxt = level - 1'b1;
         default: level_nxt = level;
      endcase
   end

   // NOTE: non-blocking assignments in clocked blocks keep every flop sampling pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         level <= level_nxt;
         full  <= (level_nxt == LW'(DEPTH));
      end
   end

   // NOTE: storage is not reset; the pointers and level alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/handshaking_master.sv
// Transmit end of the 4-phase valid/ready handshake: TX FIFO, transfer FSM, watchdog and sticky errors.
module handshaking_master
   import hs_pkg::*;
#(
   parameter int DATA_W  = HS_DATA_W,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W-1:0]        tx_data,
   input  logic                     tx_push,
   output logic                     tx_full,
   output logic [$clog2(DEPTH):0]   tx_level,
   output logic [DATA_W-1:0]        data_out,
   output logic                     data_valid,
   input  logic                     data_ready,
   output logic                     busy,
   input  logic                     err_clr,
   output logic                     timeout_err,
   output logic                     overflow
);

   localparam int CW = $clog2(TIMEOUT + 1);

   hs_state_e         state;
   hs_state_e         state_nxt;
   logic [DATA_W-1:0] fifo_rdata;
   logic              fifo_empty;
   logic              fifo_pop;
   logic              word_avail;
   logic              abort;
   logic              wd_expired;
   logic [CW-1:0]     wd_cnt;

   hs_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .pop   (fifo_pop),
      .wdata (tx_data),
      .rdata (fifo_rdata),
      .full  (tx_full),
      .empty (fifo_empty),
      .level (tx_level)
   );

   // The abort fires on the edge the count would reach TIMEOUT; a same-edge handshake still wins.
   assign wd_expired = (wd_cnt == CW'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      fifo_pop  = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (word_avail && !fifo_empty) begin
               fifo_pop  = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (data_ready) begin
               state_nxt = REL;
            end else if (wd_expired) begin
               abort     = 1'b1;
               state_nxt = ABORT;
            end
         end
         REL: begin
            if (!data_ready) begin
               state_nxt = IDLE;
            end else if (wd_expired) begin
               abort     = 1'b1;
               state_nxt = ABORT;
            end
         end
         ABORT: begin
            if (!data_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         word_avail  <= 1'b0;
         wd_cnt      <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         state      <= state_nxt;
         // One cycle of slack between a word landing in the FIFO and the FSM taking it.
         word_avail <= !fifo_empty;
         if ((state == REQ || state == REL) && state_nxt == state) begin
            wd_cnt <= wd_cnt + 1'b1;
         end else begin
            wd_cnt <= '0;
         end
         if (fifo_pop) data_out <= fifo_rdata;
         data_valid <= (state_nxt == REQ);
         busy       <= (state_nxt != IDLE);
         // A fresh error outranks a clear in the same cycle.
         if (abort) begin
            timeout_err <= 1'b1;
         end else if (err_clr) begin
            timeout_err <= 1'b0;
         end
         if (tx_push && tx_full) begin
            overflow <= 1'b1;
         end else if (err_clr) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_handshaking_master.sv
// Bench for handshaking_master: behavioural slave responder, word scoreboard, vector table plus corner sequences.
module tb_handshaking_master;
   import hs_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int TO    = 32;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] tx_data = '0;
   logic          tx_push = 1'b0;
   logic          tx_full;
   logic [LW-1:0] tx_level;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          data_ready;
   logic          busy;
   logic          err_clr = 1'b0;
   logic          timeout_err;
   logic          overflow;

   always #5 clk = ~clk;

   handshaking_master #(
      .DATA_W  (DW),
      .DEPTH   (DEPTH),
      .TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_push     (tx_push),
      .tx_full     (tx_full),
      .tx_level    (tx_level),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .busy        (busy),
      .err_clr     (err_clr),
      .timeout_err (timeout_err),
      .overflow    (overflow)
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] sb[$];

   typedef enum {R_OFF, R_ECHO, R_HIGH, R_RAND} resp_e;
   resp_e resp_mode = R_OFF;
   int    ack_delay = 1;

   typedef struct {
      logic [DW-1:0] data;
      int            delay;   // 0: slave never acknowledges
      bit            abort;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Slave model: raises data_ready once valid has been seen for ack_delay samples, drops it with valid.
   initial begin
      int vcnt = 0;
      data_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         vcnt = data_valid ? vcnt + 1 : 0;
         case (resp_mode)
            R_ECHO:  data_ready = data_valid && (vcnt >= ack_delay);
            R_HIGH:  data_ready = 1'b1;
            R_RAND:  data_ready = 1'($urandom_range(0, 1));
            default: data_ready = 1'b0;
         endcase
      end
   end

   // Scoreboard: each rising data_valid must present the oldest queued word, held stable while valid.
   initial begin
      logic          prev = 1'b0;
      logic [DW-1:0] held = '0;
      logic [DW-1:0] exp;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev = 1'b0;
         end else begin
            if (data_valid && !prev) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL send_unexpected: data_out=%0h presented with no word queued (t=%0t)", data_out, $time);
               end else begin
                  exp = sb.pop_front();
                  check("send_data", data_out, exp);
               end
               held = data_out;
            end else if (data_valid && prev) begin
               check("data_stable", data_out, held);
            end
            prev = data_valid;
         end
      end
   end

   task automatic drive_push(input logic [DW-1:0] d, input bit accepted);
      tx_data = d;
      tx_push = 1'b1;
      if (accepted) sb.push_back(d);
      @(negedge clk);
      tx_push = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!data_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic count_valid(output int vc);
      vc = 0;
      while (data_valid && vc < TO + 10) begin
         @(negedge clk);
         vc++;
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((busy || data_valid || tx_level != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("drain_busy", busy, 0);
      check("drain_level", tx_level, 0);
      check("drain_sb_empty", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t vecs[6];
      int   lat;
      int   vc;
      int   n;
      bit   seen;

      vecs[0] = '{8'hD4, 1, 1'b0};
      vecs[1] = '{8'h5A, 2, 1'b0};
      vecs[2] = '{8'hA5, 7, 1'b0};
      vecs[3] = '{8'h00, TO - 1, 1'b0};
      vecs[4] = '{8'h3C, 0, 1'b1};
      vecs[5] = '{8'hC3, 1, 1'b0};

      // Reset held while inputs toggle
      resp_mode = R_RAND;
      repeat (6) begin
         @(negedge clk);
         tx_push = 1'($urandom_range(0, 1));
         tx_data = DW'($urandom);
         err_clr = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check("rst_valid", data_valid, 0);
      check("rst_data_out", data_out, 0);
      check("rst_busy", busy, 0);
      check("rst_full", tx_full, 0);
      check("rst_level", tx_level, 0);
      check("rst_timeout_err", timeout_err, 0);
      check("rst_overflow", overflow, 0);
      tx_push   = 1'b0;
      err_clr   = 1'b0;
      resp_mode = R_OFF;
      @(negedge clk);
      rst = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("idle_valid", data_valid, 0);
      end

      // Single-word transfers across slave response times
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         err_clr = 1'b1;
         @(negedge clk);
         err_clr = 1'b0;
         check("err_cleared", timeout_err, 0);
         resp_mode = (vecs[i].delay == 0) ? R_OFF : R_ECHO;
         ack_delay = vecs[i].delay;
         drive_push(vecs[i].data, 1'b1);
         wait_valid(lat);
         check("push_to_valid_latency", lat, 2);
         count_valid(vc);
         check("valid_cycles", vc, vecs[i].abort ? TO : vecs[i].delay);
         check("timeout_err", timeout_err, 32'(vecs[i].abort));
         wait_drain();
      end

      // Fill while the slave stalls, overflow, clear priority
      resp_mode = R_OFF;
      drive_push(8'hA0, 1'b1);
      wait_valid(lat);
      check("stall_latency", lat, 2);
      drive_push(8'h01, 1'b1);
      drive_push(8'h02, 1'b1);
      drive_push(8'h03, 1'b1);
      drive_push(8'h04, 1'b1);
      check("fill_level", tx_level, 4);
      check("fill_full", tx_full, 1);
      check("fill_no_overflow", overflow, 0);
      drive_push(8'h05, 1'b0);
      check("overflow_set", overflow, 1);
      check("overflow_level", tx_level, 4);
      tx_data = 8'h06;
      tx_push = 1'b1;
      err_clr = 1'b1;
      @(negedge clk);
      tx_push = 1'b0;
      err_clr = 1'b0;
      check("overflow_beats_clear", overflow, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("overflow_cleared", overflow, 0);
      resp_mode = R_ECHO;
      ack_delay = 1;
      wait_drain();

      // Reset in REQ with two words queued
      resp_mode = R_OFF;
      drive_push(8'h11, 1'b1);
      wait_valid(lat);
      drive_push(8'h22, 1'b1);
      drive_push(8'h33, 1'b1);
      check("pre_rst_level", tx_level, 2);
      check("pre_rst_valid", data_valid, 1);
      #2;
      rst = 1'b0;
      sb.delete();
      #1;
      check("mid_rst_valid", data_valid, 0);
      check("mid_rst_level", tx_level, 0);
      check("mid_rst_busy", busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst  = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (data_valid) seen = 1'b1;
      end
      check("no_stale_word", seen, 0);
      check("post_rst_level", tx_level, 0);

      // Push and pop in the same cycle at level 2
      drive_push(8'h41, 1'b1);
      wait_valid(lat);
      drive_push(8'h42, 1'b1);
      drive_push(8'h43, 1'b1);
      check("pp_level_before", tx_level, 2);
      resp_mode = R_ECHO;
      ack_delay = 1;
      n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("pp_idle_level", tx_level, 2);
      drive_push(8'h44, 1'b1);
      check("pp_level_after", tx_level, 2);
      check("pp_valid", data_valid, 1);
      wait_drain();

      // data_ready held high in IDLE must not start anything
      resp_mode = R_HIGH;
      repeat (5) @(negedge clk);
      check("ready_idle_busy", busy, 0);
      check("ready_idle_level", tx_level, 0);
      check("ready_idle_valid", data_valid, 0);
      resp_mode = R_OFF;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
